card_key_encoder: RTL and testbench

Front-end that produces the card-event pulses consumed by the blackjack counter. It takes five raw, bouncy, asynchronous push-button levels, then synchronizes and debounces each one. It turns every debounced press into exactly one single-cycle pulse on the matching output (`large_add`, `seven_add`, `small_add`, `deck_add`, `back`), at most one pulse per cycle. Its outputs connect directly to the counter's same-named inputs.

---
 rtl/card_key_pkg.sv | 26 ++
 rtl/key_debounce.sv | 51 +++++
 rtl/card_key_encoder.sv | 78 +++++++
 tb/tb_card_key_encoder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/card_key_pkg.sv
// Shared key indices, priority order and the fixed-priority pick used by the
// card key encoder.
package card_key_pkg;
  localparam int NUM_KEYS  = 5;
  localparam int KEY_SMALL = 0;
  localparam int KEY_SEVEN = 1;
  localparam int KEY_LARGE = 2;
  localparam int KEY_BACK  = 3;
  localparam int KEY_DECK  = 4;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  // Highest priority first.
  localparam int PRIO [NUM_KEYS] = '{KEY_DECK, KEY_BACK, KEY_LARGE, KEY_SEVEN, KEY_SMALL};

  // One-hot grant of the highest-priority requester; the scan runs from the
  // lowest priority upward so the last hit wins.
  function automatic key_vec_t prio_pick(input key_vec_t req);
    key_vec_t g;
    g = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (req[PRIO[i]]) g = key_vec_t'(1) << PRIO[i];
    end
    return g;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchronizer, stability counter and accepted level.
// press is a combinational strobe coinciding with the edge that accepts a 0->1.
module key_debounce
  import card_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             d_q, d_d;
  logic [CNT_W-1:0] c_q, c_d;

  always_comb begin
    d_d   = d_q;
    c_d   = c_q;
    press = 1'b0;
    if (sync2_q == d_q) begin
      c_d = '0;
    end else if (c_q == LAST) begin
      d_d   = sync2_q;
      c_d   = '0;
      press = sync2_q;
    end else begin
      c_d = c_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      d_q     <= 1'b0;
      c_q     <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      d_q     <= d_d;
      c_q     <= c_d;
    end
  end

  assign level = d_q;
endmodule

// File: rtl/card_key_encoder.sv
// Debounces five card buttons and serializes accepted presses into
// single-cycle event pulses, one per cycle, deck > back > large > seven > small.
module card_key_encoder
  import card_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_large,
  input  logic btn_seven,
  input  logic btn_small,
  input  logic btn_deck,
  input  logic btn_back,
  output logic large_add,
  output logic seven_add,
  output logic small_add,
  output logic deck_add,
  output logic back,
  output logic busy,
  output logic dropped
);
  key_vec_t btn_raw, press, lvl_unused;
  key_vec_t pending_q, pending_d, grant, ev_q;
  logic     busy_q, dropped_q, dropped_d;

  always_comb begin
    btn_raw            = '0;
    btn_raw[KEY_SMALL] = btn_small;
    btn_raw[KEY_SEVEN] = btn_seven;
    btn_raw[KEY_LARGE] = btn_large;
    btn_raw[KEY_BACK]  = btn_back;
    btn_raw[KEY_DECK]  = btn_deck;
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[k]),
      .level(lvl_unused[k]),
      .press(press[k])
    );
  end

  // A new press ORs in after the clear, so set beats clear on the same edge.
  always_comb begin
    grant     = prio_pick(pending_q);
    pending_d = (pending_q & ~grant) | press;
    dropped_d = |(press & pending_q & ~grant);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      ev_q      <= '0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ev_q      <= grant;
      busy_q    <= |pending_d;
      dropped_q <= dropped_d;
    end
  end

  assign small_add = ev_q[KEY_SMALL];
  assign seven_add = ev_q[KEY_SEVEN];
  assign large_add = ev_q[KEY_LARGE];
  assign back      = ev_q[KEY_BACK];
  assign deck_add  = ev_q[KEY_DECK];
  assign busy      = busy_q;
  assign dropped   = dropped_q;
endmodule

// File: tb/tb_card_key_encoder.sv
// Directed table-driven bench for card_key_encoder with DEBOUNCE_CYCLES=4.
module tb_card_key_encoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;  // [4]=deck [3]=back [2]=large [1]=seven [0]=small
  logic       large_add, seven_add, small_add, deck_add, back, busy, dropped;
  logic [4:0] ev;

  int total = 0;
  int bad   = 0;
  int ec    = 0;

  typedef struct {
    logic [4:0] btn;
    logic [4:0] ev;
    logic       busy;
    logic       drop;
  } vec_t;
  vec_t tbl [0:40];

  card_key_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_large(btn[2]),
    .btn_seven(btn[1]),
    .btn_small(btn[0]),
    .btn_deck (btn[4]),
    .btn_back (btn[3]),
    .large_add(large_add),
    .seven_add(seven_add),
    .small_add(small_add),
    .deck_add (deck_add),
    .back     (back),
    .busy     (busy),
    .dropped  (dropped)
  );

  assign ev = {deck_add, back, large_add, seven_add, small_add};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int at, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge %0d: got %0h want %0h", nm, at, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ec++;
    #1;
  endtask

  // Leaves us 3ns after an edge with rst low; the next edge is edge 1.
  task automatic do_reset();
    rst = 1'b1;
    btn = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    ec = 0;
  endtask

  task automatic tbl_clear();
    for (int k = 0; k <= 40; k++) begin
      tbl[k].btn  = '0;
      tbl[k].ev   = '0;
      tbl[k].busy = 1'b0;
      tbl[k].drop = 1'b0;
    end
  endtask

  task automatic run_tbl(input string nm, input int n);
    do_reset();
    for (int k = 1; k <= n; k++) begin
      btn = tbl[k].btn;
      step();
      chk({nm, ".ev"},   ec, 32'(ev),      32'(tbl[k].ev));
      chk({nm, ".busy"}, ec, 32'(busy),    32'(tbl[k].busy));
      chk({nm, ".drop"}, ec, 32'(dropped), 32'(tbl[k].drop));
    end
  endtask

  initial begin
    // Reset values while rst is held.
    #2;
    chk("rst.ev",   0, 32'(ev),      32'd0);
    chk("rst.busy", 0, 32'(busy),    32'd0);
    chk("rst.drop", 0, 32'(dropped), 32'd0);

    // Clean press of small, held then released.
    tbl_clear();
    for (int k = 10; k <= 22; k++) tbl[k].btn = 5'b00001;
    tbl[15].busy = 1'b1;
    tbl[16].ev   = 5'b00001;
    run_tbl("clean", 30);

    // Bounce on large: sampled 1,1,0 then 1 held from edge 13.
    tbl_clear();
    tbl[10].btn = 5'b00100;
    tbl[11].btn = 5'b00100;
    for (int k = 13; k <= 26; k++) tbl[k].btn = 5'b00100;
    tbl[18].busy = 1'b1;
    tbl[19].ev   = 5'b00100;
    run_tbl("bounce", 26);

    // All five together: served deck, back, large, seven, small.
    tbl_clear();
    for (int k = 10; k <= 26; k++) tbl[k].btn = 5'b11111;
    for (int k = 15; k <= 19; k++) tbl[k].busy = 1'b1;
    tbl[16].ev = 5'b10000;
    tbl[17].ev = 5'b01000;
    tbl[18].ev = 5'b00100;
    tbl[19].ev = 5'b00010;
    tbl[20].ev = 5'b00001;
    run_tbl("simul", 26);

    // Glitch on seven shorter than the debounce window.
    tbl_clear();
    for (int k = 10; k <= 12; k++) tbl[k].btn = 5'b00010;
    run_tbl("glitch", 24);

    // Async reset while a pulse is on the outputs, then idle for 10 cycles.
    do_reset();
    btn = 5'b10000;
    for (int k = 1; k <= 7; k++) step();
    chk("midrst.pre_ev", ec, 32'(ev), 32'b10000);
    #2 rst = 1'b1;
    #1;
    chk("midrst.ev",   ec, 32'(ev),      32'd0);
    chk("midrst.busy", ec, 32'(busy),    32'd0);
    chk("midrst.drop", ec, 32'(dropped), 32'd0);
    btn = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    ec = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("idle.ev",   ec, 32'(ev),      32'd0);
      chk("idle.busy", ec, 32'(busy),    32'd0);
      chk("idle.drop", ec, 32'(dropped), 32'd0);
    end

    // Deck held across a reset pulse at edge 13: counted afresh afterwards.
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      btn = (k >= 10) ? 5'b10000 : 5'b00000;
      step();
      chk("rcnt.pre_ev", ec, 32'(ev), 32'd0);
    end
    #1 rst = 1'b1;
    #1;
    chk("rcnt.rst_ev", ec, 32'(ev), 32'd0);
    @(posedge clk);
    #4 rst = 1'b0;
    ec = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("rcnt.ev",   ec, 32'(ev),   (k == 7) ? 32'b10000 : 32'd0);
      chk("rcnt.busy", ec, 32'(busy), (k == 6) ? 32'd1     : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
